// File: rtl/mem_rd_arbiter_if.sv
// Two-requester read bus: request/ready handshake plus one-cycle response strobe per requester.
interface mem_rd_arbiter_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
);
  logic                  rq0_valid;
  logic [DEPTH_LOG2-1:0] rq0_addr;
  logic                  rq0_ready;
  logic                  rsp0_valid;
  logic [WIDTH-1:0]      rsp0_data;

  logic                  rq1_valid;
  logic [DEPTH_LOG2-1:0] rq1_addr;
  logic                  rq1_ready;
  logic                  rsp1_valid;
  logic [WIDTH-1:0]      rsp1_data;

  modport master (
    output rq0_valid, rq0_addr, rq1_valid, rq1_addr,
    input  rq0_ready, rsp0_valid, rsp0_data, rq1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  rq0_valid, rq0_addr, rq1_valid, rq1_addr,
    output rq0_ready, rsp0_valid, rsp0_data, rq1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Clears memory after reset, then arbitrates two read requesters (round-robin on contention) onto one memory read port.
// MEM_RD_ARB_BYPASS_EN: forward same-cycle write data to a read of the same address.
module mem_rd_arbiter #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_rd_arbiter_if.slave       rq,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  init_done,
  output logic                  mem_read,
  output logic [DEPTH_LOG2-1:0] mem_read_addr,
  input  logic [WIDTH-1:0]      mem_read_data,
  output logic                  mem_write,
  output logic [DEPTH_LOG2-1:0] mem_write_addr,
  output logic [WIDTH-1:0]      mem_write_data
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2-1:0] cnt_q;
  logic                  ptr_q, ptr_d;
  logic                  pend_vld_q, pend_id_q;
  logic [WIDTH-1:0]      rsp0_data_q, rsp1_data_q;
  logic                  init_done_q;

  logic                  run, gnt0, gnt1, rsp0_vld, rsp1_vld;
  logic [DEPTH_LOG2-1:0] gnt_addr;
  logic [WIDTH-1:0]      rd_dat;

  // Asserting rst_n gates everything at once so an in-flight read never strobes out.
  assign run      = (state_q == RUN) && rst_n;
  assign gnt0     = run && rq.rq0_valid && (!rq.rq1_valid || !ptr_q);
  assign gnt1     = run && rq.rq1_valid && (!rq.rq0_valid || ptr_q);
  assign gnt_addr = gnt1 ? rq.rq1_addr : rq.rq0_addr;
  assign ptr_d    = ((gnt0 || gnt1) && rq.rq0_valid && rq.rq1_valid) ? !ptr_q : ptr_q;

  assign rq.rq0_ready  = gnt0;
  assign rq.rq1_ready  = gnt1;
  assign mem_read      = gnt0 || gnt1;
  assign mem_read_addr = gnt_addr;

  assign mem_write      = (state_q == INIT) || (run && wr_en);
  assign mem_write_addr = (state_q == INIT) ? cnt_q : wr_addr;
  assign mem_write_data = (state_q == INIT) ? '0 : wr_data;

`ifdef MEM_RD_ARB_BYPASS_EN
  logic             byp_q;
  logic [WIDTH-1:0] byp_dat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_q     <= wr_en && (wr_addr == gnt_addr);
      byp_dat_q <= wr_data;
    end
  end

  assign rd_dat = byp_q ? byp_dat_q : mem_read_data;
`else
  assign rd_dat = mem_read_data;
`endif

  assign rsp0_vld      = rst_n && pend_vld_q && !pend_id_q;
  assign rsp1_vld      = rst_n && pend_vld_q && pend_id_q;
  assign rq.rsp0_valid = rsp0_vld;
  assign rq.rsp1_valid = rsp1_vld;
  assign rq.rsp0_data  = rsp0_vld ? rd_dat : rsp0_data_q;
  assign rq.rsp1_data  = rsp1_vld ? rd_dat : rsp1_data_q;
  assign init_done     = init_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_id_q   <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      end
      ptr_q      <= ptr_d;
      pend_vld_q <= gnt0 || gnt1;
      pend_id_q  <= gnt1;
      if (rsp0_vld) rsp0_data_q <= rd_dat;
      if (rsp1_vld) rsp1_data_q <= rd_dat;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed + random bench for mem_rd_arbiter against a queue/array reference model and a 1-cycle-latency memory.
module tb_mem_rd_arbiter;
  localparam int DL = 4;
  localparam int W  = 32;
  localparam int N  = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          init_done;
  logic          mem_read;
  logic [DL-1:0] mem_read_addr;
  logic [W-1:0]  mem_read_data;
  logic          mem_write;
  logic [DL-1:0] mem_write_addr;
  logic [W-1:0]  mem_write_data;

  mem_rd_arbiter_if #(.DEPTH_LOG2(DL), .WIDTH(W)) rq_if ();

  mem_rd_arbiter #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .rq(rq_if),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency; a same-address write in the read cycle returns the old word.
  logic [W-1:0] tmem [N];
  always @(posedge clk) begin
    if (mem_read)  mem_read_data <= tmem[mem_read_addr];
    if (mem_write) tmem[mem_write_addr] <= mem_write_data;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: memory contents, whose turn under contention, expected next response.
  logic [W-1:0] shadow [N];
  bit           turn;
  bit           pend_vld;
  bit           pend_id;
  logic [W-1:0] pend_dat;
  logic [W-1:0] last_dat [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rq_if.rq0_valid = 1'b0; rq_if.rq0_addr = '0;
    rq_if.rq1_valid = 1'b0; rq_if.rq1_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) shadow[i] = '0;
    turn = 1'b0;
    pend_vld = 1'b0;
    pend_id = 1'b0;
    last_dat[0] = '0;
    last_dat[1] = '0;
  endtask

  // Called in the first window after rst_n is released; covers the whole clear plus the first RUN cycle.
  task automatic do_clear();
    for (int i = 0; i < N; i++) begin
      rq_if.rq0_valid = 1'b1; rq_if.rq0_addr = DL'($urandom_range(0, N - 1));
      rq_if.rq1_valid = 1'b1; rq_if.rq1_addr = DL'($urandom_range(0, N - 1));
      wr_en = 1'b1; wr_addr = DL'(i ^ 5); wr_data = 32'hBAD0_0000 | i;
      #3;
      chk("clr_mem_write", mem_write, 1);
      chk("clr_addr", mem_write_addr, i);
      chk("clr_data", mem_write_data, 0);
      chk("clr_ready0", rq_if.rq0_ready, 0);
      chk("clr_ready1", rq_if.rq1_ready, 0);
      chk("clr_mem_read", mem_read, 0);
      chk("clr_rsp0_valid", rq_if.rsp0_valid, 0);
      chk("clr_rsp1_valid", rq_if.rsp1_valid, 0);
      chk("clr_init_done", init_done, 0);
      next_cyc();
    end
    drive_idle();
    #3;
    chk("init_done_rise", init_done, 1);
    chk("run_idle_write", mem_write, 0);
    next_cyc();
  endtask

  // One RUN cycle: drive, check against model, advance model, step clock.
  task automatic cyc(input bit v0, input int a0, input bit v1, input int a1,
                     input bit we, input int wa, input logic [W-1:0] wd);
    bit g0, g1;
    int ga;
    rq_if.rq0_valid = v0; rq_if.rq0_addr = DL'(a0);
    rq_if.rq1_valid = v1; rq_if.rq1_addr = DL'(a1);
    wr_en = we; wr_addr = DL'(wa); wr_data = wd;
    #3;
    chk("rsp0_valid", rq_if.rsp0_valid, pend_vld && !pend_id);
    chk("rsp1_valid", rq_if.rsp1_valid, pend_vld && pend_id);
    if (pend_vld) last_dat[pend_id] = pend_dat;
    chk("rsp0_data", rq_if.rsp0_data, last_dat[0]);
    chk("rsp1_data", rq_if.rsp1_data, last_dat[1]);
    if (v0 && v1) begin
      g0 = (turn == 1'b0);
      g1 = !g0;
      turn = !turn;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    ga = g1 ? a1 : a0;
    chk("ready0", rq_if.rq0_ready, g0);
    chk("ready1", rq_if.rq1_ready, g1);
    chk("mem_read", mem_read, g0 || g1);
    if (g0 || g1) chk("mem_read_addr", mem_read_addr, ga);
    chk("mem_write", mem_write, we);
    if (we) begin
      chk("mem_write_addr", mem_write_addr, wa);
      chk("mem_write_data", mem_write_data, wd);
    end
    pend_vld = g0 || g1;
    pend_id  = g1;
    pend_dat = shadow[ga];
`ifdef MEM_RD_ARB_BYPASS_EN
    if (we && wa == ga) pend_dat = wd;
`endif
    if (we) shadow[wa] = wd;
    next_cyc();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    next_cyc();
    next_cyc();
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp0_valid", rq_if.rsp0_valid, 0);
    chk("rst_rsp1_valid", rq_if.rsp1_valid, 0);
    chk("rst_rsp0_data", rq_if.rsp0_data, 0);
    chk("rst_rsp1_data", rq_if.rsp1_data, 0);
    rst_n = 1'b1;
    do_clear();

    // Cleared words read back as zero, including the address written during the clear.
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("deadbeef_hold", rq_if.rsp0_data, 32'hDEADBEEF);

    // Continuous contention: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      rq_if.rq0_valid = 1'b1; rq_if.rq0_addr = 4'd3;
      rq_if.rq1_valid = 1'b1; rq_if.rq1_addr = 4'd4;
      #1;
      chk("contend_grant0", rq_if.rq0_ready, (i % 2) == 0);
      #0;
      cyc(1, 3, 1, 4, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Same-cycle read and write of address 5.
    cyc(0, 0, 1, 5, 1, 5, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_RD_ARB_BYPASS_EN
    chk("bypass_data", rq_if.rsp1_data, 32'h12345678);
`else
    chk("nobypass_data", rq_if.rsp1_data, 0);
`endif
    cyc(0, 0, 1, 5, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, N - 1),
          $urandom_range(0, 1), $urandom_range(0, N - 1),
          $urandom_range(0, 1), $urandom_range(0, N - 1), $urandom);
    end

    // Reset in the cycle after a grant: the read is discarded and the clear restarts.
    cyc(1, 9, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    chk("rstmid_rsp0_valid", rq_if.rsp0_valid, 0);
    chk("rstmid_rsp1_valid", rq_if.rsp1_valid, 0);
    next_cyc();
    chk("rstmid_init_done", init_done, 0);
    chk("rstmid_rsp0_data", rq_if.rsp0_data, 0);
    chk("rstmid_rsp1_valid2", rq_if.rsp1_valid, 0);
    model_reset();
    rst_n = 1'b1;
    do_clear();
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving log2 of the memory entry count.
REQ-002 SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have ports rq0_valid / rq1_valid, input, 1 bit each: read request from requester 0 / 1.
REQ-007 SHALL have ports rq0_addr / rq1_addr, input, DEPTH_LOG2 bits each: read address.
REQ-008 SHALL have ports rq0_ready / rq1_ready, output, 1 bit each: request accepted this cycle.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: one-cycle response strobe.
REQ-010 SHALL have ports rsp0_data / rsp1_data, output, WIDTH bits each: read result.
REQ-011 SHALL have ports wr_en (input, 1 bit), wr_addr (input, DEPTH_LOG2 bits) and wr_data (input, WIDTH bits): single write requester.
REQ-012 SHALL have port init_done, output, 1 bit: high once memory clear has completed.
REQ-013 SHALL have ports mem_read (output, 1 bit), mem_read_addr (output, DEPTH_LOG2 bits) and mem_read_data (input, WIDTH bits): memory read port.
REQ-014 SHALL have ports mem_write (output, 1 bit), mem_write_addr (output, DEPTH_LOG2 bits) and mem_write_data (output, WIDTH bits): memory write port.

Function
REQ-015 SHALL implement an FSM with states INIT and RUN; reset enters INIT with clear counter 0.
REQ-016 In INIT, SHALL assert mem_write with mem_write_addr = counter and mem_write_data = 0, incrementing counter each cycle.
REQ-017 SHALL transition INIT->RUN on the cycle after writing address 2^DEPTH_LOG2-1; the clear therefore takes exactly 2^DEPTH_LOG2 cycles, and init_done rises on the first RUN cycle.
REQ-018 In INIT, rq*_ready, mem_read and rsp*_valid SHALL be 0, and wr_en SHALL be ignored (write dropped).
REQ-019 In RUN, mem_write/mem_write_addr/mem_write_data SHALL combinationally equal wr_en/wr_addr/wr_data.
REQ-020 In RUN, at most one read request SHALL be accepted per cycle; rqN_ready is combinational from the valids and the priority pointer.
REQ-021 With a single valid requester, that requester SHALL be granted.
REQ-022 With both requesters valid, the requester named by the priority pointer SHALL be granted; the pointer then moves to the other requester.
REQ-023 The pointer SHALL change only on a grant made under contention, reset to requester 0, and alternate grants under continuous contention.
REQ-024 On a grant, SHALL drive mem_read=1 and mem_read_addr = the granted address in the same cycle; mem_read SHALL be 0 otherwise.
REQ-025 rspN_valid SHALL pulse exactly one cycle after requester N's grant, with rspN_data = mem_read_data in that cycle; there is no response backpressure.
REQ-026 rspN_data SHALL hold its last value when rspN_valid is 0.
REQ-027 SHALL keep registered pending state (valid, requester id) for the one in-flight read.

Reset
REQ-028 On rst_n=0: FSM=INIT, counter=0, pointer=0, pending cleared, init_done=0, rsp*_valid=0, rsp*_data=0.
REQ-029 Reset asserted mid-RUN SHALL discard any in-flight read (no rsp*_valid afterwards) and restart the clear.

Configuration
REQ-030 Macro MEM_RD_ARB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With MEM_RD_ARB_BYPASS_EN defined: if wr_en=1 and wr_addr equals the granted read address in the grant cycle, the response SHALL carry that cycle's wr_data instead of mem_read_data.
REQ-032 Without MEM_RD_ARB_BYPASS_EN: the response SHALL always carry mem_read_data, and same-address read-during-write data is memory-defined.

Verification
REQ-033 Reset, DEPTH_LOG2=4 -> mem_write=1 with addresses 0..15 and data 0 for 16 cycles, ready=0 throughout, init_done=1 on cycle 17; wr_en during the clear is dropped.
REQ-034 Write 0xDEADBEEF to address 3, then rq0 reads address 3 -> rsp0_valid one cycle after grant, rsp0_data=0xDEADBEEF.
REQ-035 Both valid for 4 cycles after reset -> grants 0,1,0,1, and rsp0/rsp1 strobes follow one cycle later.
REQ-036 Bypass enabled: rq1 reads address 5 while writing 0x12345678 to address 5 in the same cycle -> rsp1_data=0x12345678.
REQ-037 rst_n=0 in the cycle after a grant -> no rsp*_valid, init_done=0, and the clear restarts at address 0.
